mips_cpu_mem_bridge: RTL and testbench

Bus interface unit between the multicycle CPU's data/instruction bus master and the external Avalon-MM memory. It accepts right-justified byte/half/word requests at any byte address and issues word-aligned Avalon transfers with the correct byteenable and lane-replicated writedata. It extracts and optionally sign-extends read data, stalls the CPU through its own waitrequest, and reports misaligned, illegal or timed-out accesses as a one-cycle fault.

---
 rtl/mips_cpu_mem_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_mips_cpu_mem_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_bridge.sv
// -----------------------------------------------------------------------------
// mips_cpu_mem_bridge
//
// Bus interface unit between the multicycle CPU's load/store master and an
// Avalon-MM memory. A CPU request is latched in IDLE and then turned into one
// word-aligned Avalon transfer in BUS. That transfer carries the byteenable for
// the addressed lanes and lane-replicated store data. Load data is extracted,
// right-justified and optionally sign-extended. The CPU sees a single-cycle
// completion (RESP) or a single-cycle abort (FAULT).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_address         byte address of the access
//   cpu_read/cpu_write  request strobes, held until cpu_waitrequest is low
//   cpu_size            00 byte, 01 half, 10 word, 11 illegal
//   cpu_signed          sign-extend byte/half loads
//   cpu_writedata       right-justified store data
//   cpu_readdata        right-justified load data (holds until the next load)
//   cpu_waitrequest     stall to CPU
//   cpu_fault           one-cycle pulse when an access is aborted
//   avm_*               Avalon-MM master towards memory
// -----------------------------------------------------------------------------
module mips_cpu_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic        cpu_fault,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched copy of the request; the CPU may wiggle its inputs while stalled.
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_signed;

    logic [31:0]      r_avm_address;
    logic             r_avm_read;
    logic             r_avm_write;
    logic [31:0]      r_avm_writedata;
    logic [3:0]       r_avm_byteenable;
    logic [31:0]      r_cpu_readdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_req;
    logic             w_illegal;
    logic             w_timeout;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [31:0]      w_wd;
    logic [15:0]      w_lane;
    logic [31:0]      w_extract;

    assign w_req = cpu_read | cpu_write;
    assign w_off = cpu_address[1:0];

    // Request legality: exactly one direction, legal size, natural alignment.
    always_comb begin
        w_illegal = cpu_read & cpu_write;
        case (cpu_size)
            2'b01:   if (w_off[0])       w_illegal = 1'b1;
            2'b10:   if (w_off != 2'b00) w_illegal = 1'b1;
            2'b11:                       w_illegal = 1'b1;
            default: ;
        endcase
    end

    // Lane encoding from the live request; only sampled on the IDLE accept edge.
    always_comb begin
        w_be = 4'b1111;
        w_wd = cpu_writedata;
        case (cpu_size)
            2'b00: begin
                w_be = 4'b0001 << w_off;
                w_wd = {4{cpu_writedata[7:0]}};
            end
            2'b01: begin
                w_be = 4'b0011 << w_off;
                w_wd = {2{cpu_writedata[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    assign w_lane = 16'(avm_readdata >> {r_off, 3'b000});

    always_comb begin
        w_extract = avm_readdata;
        case (r_size)
            2'b00:   w_extract = {{24{r_signed & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_extract = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: ;
        endcase
    end

    // r_cnt holds the number of wait cycles already seen. Aborting on the
    // TIMEOUT_CYCLES-th waiting cycle keeps the strobe up for exactly that many cycles.
    assign w_timeout = avm_waitrequest && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = w_illegal ? S_FAULT : S_BUS;
            end
            S_BUS: begin
                if (!avm_waitrequest) w_next = S_RESP;
                else if (w_timeout)   w_next = S_FAULT;
            end
            S_RESP:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off            <= 2'b00;
            r_size           <= 2'b00;
            r_signed         <= 1'b0;
            r_avm_address    <= 32'h0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= 32'h0;
            r_avm_byteenable <= 4'h0;
            r_cpu_readdata   <= 32'h0;
            r_cnt            <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_off    <= w_off;
                        r_size   <= cpu_size;
                        r_signed <= cpu_signed;
                        r_cnt    <= '0;
                        // Illegal requests never reach the bus.
                        if (!w_illegal) begin
                            r_avm_address    <= {cpu_address[31:2], 2'b00};
                            r_avm_read       <= cpu_read;
                            r_avm_write      <= cpu_write;
                            r_avm_byteenable <= w_be;
                            r_avm_writedata  <= cpu_write ? w_wd : 32'h0;
                        end
                    end
                end
                S_BUS: begin
                    if (!avm_waitrequest || w_timeout) begin
                        if (!avm_waitrequest && r_avm_read) r_cpu_readdata <= w_extract;
                        r_avm_read       <= 1'b0;
                        r_avm_write      <= 1'b0;
                        r_avm_byteenable <= 4'h0;
                        r_avm_writedata  <= 32'h0;
                        r_cnt            <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_waitrequest = w_req && (r_state != S_RESP) && (r_state != S_FAULT);
    assign cpu_fault       = (r_state == S_FAULT);
    assign cpu_readdata    = r_cpu_readdata;
    assign avm_address     = r_avm_address;
    assign avm_read        = r_avm_read;
    assign avm_write       = r_avm_write;
    assign avm_writedata   = r_avm_writedata;
    assign avm_byteenable  = r_avm_byteenable;

endmodule

// File: tb/tb_mips_cpu_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_mem_bridge
//
// Drives CPU requests (directed and random) into the bridge while a small
// Avalon slave with programmable wait states serves them. Expected CPU
// responses and expected bus transfers are pushed into queues when each
// request is issued. Two monitors pop and compare whenever the DUT completes
// a CPU access or drops a bus strobe.
// -----------------------------------------------------------------------------
module tb_mips_cpu_mem_bridge;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        cpu_fault;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic        avm_waitrequest;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;

    always #5 clk = ~clk;

    mips_cpu_mem_bridge #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest), .cpu_fault(cpu_fault),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_waitrequest(avm_waitrequest), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- Avalon slave: 16 words, aliased by address[5:2] --------
    logic [31:0] mem [16] = '{default: 32'h0};
    int          wait_cnt = 0;
    int          wait_target = 0;
    logic        strobe;
    logic [31:0] be_mask;

    assign strobe          = avm_read | avm_write;
    assign avm_waitrequest = strobe && (wait_cnt < wait_target);
    assign avm_readdata    = avm_waitrequest ? 32'hBAD0_BAD0 : mem[avm_address[5:2]];
    assign be_mask = {{8{avm_byteenable[3]}}, {8{avm_byteenable[2]}},
                      {8{avm_byteenable[1]}}, {8{avm_byteenable[0]}}};

    always @(posedge clk) begin
        if (!strobe)              wait_cnt <= 0;
        else if (avm_waitrequest) wait_cnt <= wait_cnt + 1;
        if (avm_write && !avm_waitrequest)
            mem[avm_address[5:2]] <= (mem[avm_address[5:2]] & ~be_mask) | (avm_writedata & be_mask);
    end

    // ---------------- reference model and scoreboards ------------------------
    typedef struct {
        logic        fault;
        logic [31:0] rd;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          cnt;
    } bus_t;

    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    logic [7:0]  ref_mem [64] = '{default: 8'h0};
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CPU response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && (((cpu_read | cpu_write) && !cpu_waitrequest) || cpu_fault)) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: fault=%b rd=%h with nothing outstanding", cpu_fault, cpu_readdata);
            end else begin
                e = rsp_q.pop_front();
                if (cpu_fault !== e.fault || cpu_readdata !== e.rd) begin
                    errors++;
                    $display("FAIL cpu_rsp: got fault=%b rd=%h expected fault=%b rd=%h",
                             cpu_fault, cpu_readdata, e.fault, e.rd);
                end
            end
        end
    end

    // Bus transfer monitor: captures the first strobe cycle, watches stability,
    // and compares once the strobe drops.
    int   bcnt = 0;
    bus_t cap;
    logic unstable = 1'b0;
    always @(negedge clk) begin
        bus_t e;
        if (strobe) begin
            if (bcnt == 0) begin
                cap.wr = avm_write; cap.addr = avm_address; cap.be = avm_byteenable;
                cap.wd = avm_writedata; cap.cnt = 0;
                unstable = avm_read & avm_write;
            end else if (avm_write !== cap.wr || avm_read !== !cap.wr || avm_address !== cap.addr ||
                         avm_byteenable !== cap.be || avm_writedata !== cap.wd) begin
                unstable = 1'b1;
            end
            bcnt++;
        end else if (bcnt > 0) begin
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: wr=%b addr=%h be=%b cycles=%0d", cap.wr, cap.addr, cap.be, bcnt);
            end else begin
                e = bus_q.pop_front();
                if (cap.wr !== e.wr || cap.addr !== e.addr || cap.be !== e.be ||
                    (e.wr && cap.wd !== e.wd) || bcnt != e.cnt || unstable ||
                    avm_byteenable !== 4'h0 || avm_writedata !== 32'h0) begin
                    errors++;
                    $display("FAIL bus_xfer: got wr=%b addr=%h be=%b wd=%h cycles=%0d unstable=%b idle_be=%b idle_wd=%h expected wr=%b addr=%h be=%b wd=%h cycles=%0d",
                             cap.wr, cap.addr, cap.be, cap.wd, bcnt, unstable, avm_byteenable, avm_writedata,
                             e.wr, e.addr, e.be, e.wd, e.cnt);
                end
            end
            bcnt = 0;
        end
    end

    // Issue one CPU access. Expectations are derived from byte-level memory
    // semantics, then the request is held until the bridge releases the CPU.
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int waits);
        int          nb, off, n, exp_lat;
        logic        illegal, done;
        logic [31:0] v;
        bus_t        b;
        rsp_t        r;
        off     = int'(addr[1:0]);
        nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        illegal = (rd && wr) || (sz == 2'd3) || (off % nb != 0);
        if (illegal) begin
            r.fault = 1'b1; r.rd = last_rd;
            exp_lat = 2;
        end else begin
            b.wr = wr; b.addr = addr & ~32'h3; b.be = 4'h0;
            for (int i = 0; i < nb; i++) b.be[off + i] = 1'b1;
            b.wd = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
            b.cnt = (waits >= T) ? T : waits + 1;
            bus_q.push_back(b);
            if (waits >= T) begin
                r.fault = 1'b1;
                exp_lat = T + 2;
            end else begin
                if (wr) begin
                    for (int i = 0; i < nb; i++) ref_mem[(int'(addr[5:0]) + i) % 64] = wd[8*i +: 8];
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(int'(addr[5:0]) + i) % 64];
                    if (sg && v[8*nb-1]) for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
                    last_rd = v;
                end
                r.fault = 1'b0;
                exp_lat = waits + 3;
            end
            r.rd = last_rd;
        end
        rsp_q.push_back(r);
        wait_target   = waits;
        cpu_read      = rd;
        cpu_write     = wr;
        cpu_size      = sz;
        cpu_signed    = sg;
        cpu_address   = addr;
        cpu_writedata = wd;
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (!cpu_waitrequest) done = 1'b1;
            else if (n > 1) begin
                // Already latched: these changes must have no effect.
                cpu_address   = $urandom;
                cpu_writedata = $urandom;
                cpu_size      = 2'($urandom);
                cpu_signed    = 1'($urandom);
            end
        end
        chk("latency", 32'(n), 32'(exp_lat));
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic rand_reqs(input int count);
        logic        rd, wr, sg;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          r, s, waits, gap;
        for (int k = 0; k < count; k++) begin
            r  = int'($urandom_range(0, 15));
            rd = (r == 0) || (r < 8);
            wr = (r == 0) || (r >= 8);
            s  = int'($urandom_range(0, 9));
            sz = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
            sg = 1'($urandom);
            addr = 32'h1000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) addr = addr & ~32'h1;
                if (sz == 2'd2) addr = addr & ~32'h3;
            end
            waits = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 5));
            do_req(rd, wr, sz, sg, addr, $urandom, waits);
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_address = 32'h0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_size = 2'd0; cpu_signed = 1'b0; cpu_writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", cpu_readdata, 32'h0);
        chk("reset_strobes", {30'h0, avm_read, avm_write}, 32'h0);
        chk("reset_address", avm_address, 32'h0);
        chk("reset_be_wd", {28'h0, avm_byteenable} | avm_writedata, 32'h0);
        chk("reset_cpu_flags", {30'h0, cpu_waitrequest, cpu_fault}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed accesses
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 0);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0);   // back-to-back
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h80FF0011, 1);
        do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0);
        do_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 2);
        do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 3);
        do_req(1'b1, 1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 0);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 0);   // misaligned word
        do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 0);   // misaligned half
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h0, 0);   // read and write
        do_req(1'b0, 1'b1, 2'd3, 1'b0, 32'h1000, 32'h0, 0);   // illegal size
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, 9);   // timeout
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 3);   // longest legal wait

        rand_reqs(40);

        // Reset while a read is stalled in the bus phase.
        begin
            bus_t b;
            b.wr = 1'b0; b.addr = 32'h1010; b.be = 4'hF; b.wd = 32'h0; b.cnt = 1;
            bus_q.push_back(b);
        end
        wait_target = 20;
        cpu_read = 1'b1; cpu_size = 2'd2; cpu_address = 32'h1010; cpu_signed = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_bus_read", {31'h0, avm_read}, 32'h0);
        chk("rst_mid_bus_wait", {31'h0, cpu_waitrequest}, 32'h1);
        @(posedge clk); #1;
        chk("rst_mid_bus_rd", cpu_readdata, 32'h0);
        rst = 1'b0; cpu_read = 1'b0;
        last_rd = 32'h0;
        wait_target = 0;
        @(posedge clk); #1;

        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0);
        rand_reqs(30);

        repeat (6) @(posedge clk);
        #1;
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
